// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode decoder: tracks held state of a fixed set of keys and
// emits one-cycle press/release/error pulses, all registered.
module ps2_key_decoder #(
   parameter int                    NUM_KEYS  = 4,
   parameter logic [8*NUM_KEYS-1:0] KEY_CODES = {8'h29, 8'h6B, 8'h74, 8'h75},
   parameter logic [NUM_KEYS-1:0]   KEY_EXT   = 4'b0111,
   parameter int                    TIMEOUT   = 50000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                byte_valid,
   input  logic [7:0]          byte_in,
   input  logic                flush,
   output logic [NUM_KEYS-1:0] key_held,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic                seq_error
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXT     = 2'd1,
      BRK     = 2'd2,
      EXT_BRK = 2'd3
   } state_t;

   state_t              state_r, state_nxt_s;
   logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
   logic [NUM_KEYS-1:0] held_r, held_nxt_s;
   logic [NUM_KEYS-1:0] press_r, press_nxt_s;
   logic [NUM_KEYS-1:0] rel_r, rel_nxt_s;
   logic                err_r, err_nxt_s;
   logic                ext_s;
   logic [NUM_KEYS-1:0] match_s;

   // A key matches only when both the code and the E0-prefix flag agree.
   function automatic logic [NUM_KEYS-1:0] key_match(input logic [7:0] code,
                                                     input logic       ext);
      logic [NUM_KEYS-1:0] m;
      m = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         m[i] = (KEY_CODES[8*i +: 8] == code) && (KEY_EXT[i] == ext);
      end
      return m;
   endfunction

   // Extended flag for the byte currently on byte_in and the keys it hits.
   always_comb begin
      ext_s   = (state_r == EXT) || (state_r == EXT_BRK);
      match_s = key_match(byte_in, ext_s);
   end

   // Next-state, timeout counter and next-output computation.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      held_nxt_s  = held_r;
      press_nxt_s = '0;
      rel_nxt_s   = '0;
      err_nxt_s   = 1'b0;
      if (flush) begin
         // flush wins over a coincident byte, which is simply dropped
         state_nxt_s = IDLE;
         cnt_nxt_s   = '0;
         held_nxt_s  = '0;
         rel_nxt_s   = held_r;
      end else if (byte_valid) begin
         cnt_nxt_s = '0;
         case (state_r)
            IDLE: begin
               case (byte_in)
                  8'hE0: state_nxt_s = EXT;
                  8'hF0: state_nxt_s = BRK;
                  8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: state_nxt_s = IDLE;
                  default: begin
                     press_nxt_s = match_s & ~held_r;
                     held_nxt_s  = held_r | match_s;
                  end
               endcase
            end
            EXT: begin
               if (byte_in == 8'hF0) begin
                  state_nxt_s = EXT_BRK;
               end else if (byte_in == 8'hE0) begin
                  state_nxt_s = EXT;
               end else begin
                  press_nxt_s = match_s & ~held_r;
                  held_nxt_s  = held_r | match_s;
                  state_nxt_s = IDLE;
               end
            end
            BRK, EXT_BRK: begin
               state_nxt_s = IDLE;
               if ((byte_in == 8'hE0) || (byte_in == 8'hF0)) begin
                  err_nxt_s = 1'b1;
               end else begin
                  rel_nxt_s  = match_s & held_r;
                  held_nxt_s = held_r & ~match_s;
               end
            end
            default: state_nxt_s = IDLE;
         endcase
      end else if (state_r != IDLE) begin
         if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
            err_nxt_s   = 1'b1;
         end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
         end
      end else begin
         cnt_nxt_s = '0;
      end
   end

   // State and output registers; reset clears everything without pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         held_r  <= '0;
         press_r <= '0;
         rel_r   <= '0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         held_r  <= held_nxt_s;
         press_r <= press_nxt_s;
         rel_r   <= rel_nxt_s;
         err_r   <= err_nxt_s;
      end
   end

   assign key_held    = held_r;
   assign key_press   = press_r;
   assign key_release = rel_r;
   assign seq_error   = err_r;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder (short TIMEOUT for speed).
module tb_ps2_key_decoder;

   localparam int TMO = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_in = 8'h00;
   logic       flush = 1'b0;
   logic [3:0] key_held, key_press, key_release;
   logic       seq_error;
   int         n_checks = 0;
   int         n_errors = 0;

   ps2_key_decoder #(.TIMEOUT(TMO)) dut (
      .clk        (clk),
      .reset      (reset),
      .byte_valid (byte_valid),
      .byte_in    (byte_in),
      .flush      (flush),
      .key_held   (key_held),
      .key_press  (key_press),
      .key_release(key_release),
      .seq_error  (seq_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Present one byte for exactly one cycle; returns on the following negedge.
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      byte_valid = 1'b1;
      byte_in    = b;
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      // reset state
      #1;
      check("rst_held", key_held, 4'b0000);
      check("rst_press", key_press, 4'b0000);
      check("rst_rel", key_release, 4'b0000);
      check("rst_err", {3'b000, seq_error}, 4'b0000);
      idle(2);
      reset = 1'b0;

      // extended key 0: press, typematic repeat, release
      send(8'hE0); send(8'h75);
      check("e75_held", key_held, 4'b0001);
      check("e75_press", key_press, 4'b0001);
      idle(1);
      check("e75_press_clr", key_press, 4'b0000);
      send(8'hE0); send(8'h75);
      check("e75_rep_held", key_held, 4'b0001);
      check("e75_rep_press", key_press, 4'b0000);
      send(8'hE0); send(8'hF0); send(8'h75);
      check("e75_brk_held", key_held, 4'b0000);
      check("e75_brk_rel", key_release, 4'b0001);
      idle(1);
      check("e75_rel_clr", key_release, 4'b0000);

      // non-extended key 3; 75 without E0 must not hit key 0
      send(8'h29);
      check("k29_held", key_held, 4'b1000);
      check("k29_press", key_press, 4'b1000);
      send(8'h75);
      check("n75_held", key_held, 4'b1000);
      check("n75_press", key_press, 4'b0000);
      send(8'hF0); send(8'h29);
      check("k29_brk_held", key_held, 4'b0000);
      check("k29_brk_rel", key_release, 4'b1000);

      // byte_in without byte_valid is ignored; ack byte ignored in IDLE
      @(negedge clk); byte_in = 8'hE0;
      @(negedge clk);
      send(8'hFA);
      send(8'h75);
      check("novalid_held", key_held, 4'b0000);
      check("novalid_press", key_press, 4'b0000);

      // duplicate E0 tolerated
      send(8'hE0); send(8'hE0); send(8'h74);
      check("dupe0_held", key_held, 4'b0010);
      check("dupe0_err", {3'b000, seq_error}, 4'b0000);

      // second key, then flush with a coincident E0 that must be dropped
      send(8'hE0); send(8'h6B);
      check("two_held", key_held, 4'b0110);
      @(negedge clk);
      flush = 1'b1; byte_valid = 1'b1; byte_in = 8'hE0;
      @(negedge clk);
      flush = 1'b0; byte_valid = 1'b0;
      check("flush_held", key_held, 4'b0000);
      check("flush_rel", key_release, 4'b0110);
      send(8'h74);
      check("post_flush_held", key_held, 4'b0000);
      check("post_flush_press", key_press, 4'b0000);

      // timeout mid-sequence
      send(8'hE0);
      idle(TMO - 1);
      check("tmo_early", {3'b000, seq_error}, 4'b0000);
      idle(1);
      check("tmo_err", {3'b000, seq_error}, 4'b0001);
      idle(1);
      check("tmo_err_clr", {3'b000, seq_error}, 4'b0000);
      send(8'h29);
      check("post_tmo_held", key_held, 4'b1000);
      check("post_tmo_press", key_press, 4'b1000);
      send(8'hF0); send(8'h29);
      check("post_tmo_rel", key_release, 4'b1000);

      // malformed break keeps key state
      send(8'hE0); send(8'h75);
      send(8'hF0); send(8'hE0);
      check("bad_brk_err", {3'b000, seq_error}, 4'b0001);
      check("bad_brk_held", key_held, 4'b0001);
      check("bad_brk_rel", key_release, 4'b0000);

      // asynchronous reset mid-sequence, no release pulse
      send(8'hE0); send(8'hF0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_rst_held", key_held, 4'b0000);
      check("mid_rst_rel", key_release, 4'b0000);
      check("mid_rst_err", {3'b000, seq_error}, 4'b0000);
      idle(1);
      reset = 1'b0;
      send(8'h75);
      check("post_rst_held", key_held, 4'b0000);
      check("post_rst_press", key_press, 4'b0000);
      check("post_rst_rel", key_release, 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 The block SHALL have parameter NUM_KEYS, default 4, giving the number of tracked keys (1..32).
REQ-002 The block SHALL have parameter KEY_CODES, default {8'h29, 8'h6B, 8'h74, 8'h75}, a packed 8*NUM_KEYS vector in which bits [8i+7:8i] hold the scancode of key i.
REQ-003 The block SHALL have parameter KEY_EXT, default 4'b0111, a NUM_KEYS-bit vector in which bit i=1 means key i requires the E0 prefix.
REQ-004 The block SHALL have parameter TIMEOUT, default 50000, giving the idle cycles allowed mid-sequence (minimum 2).
REQ-005 The block SHALL have these ports, with clock and reset first:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- byte_valid  input  1  byte_in is valid this cycle (single-cycle strobe per received byte)
- byte_in  input  8  received PS/2 byte
- flush  input  1  synchronous clear of all key state
- key_held  output  NUM_KEYS  level per key; 1 while the key is down
- key_press  output  NUM_KEYS  one-cycle pulse on a new press
- key_release  output  NUM_KEYS  one-cycle pulse on release
- seq_error  output  1  one-cycle pulse on a malformed or timed-out sequence

Function
REQ-006 The block SHALL consume byte_in only in cycles where byte_valid=1, and SHALL ignore byte_in otherwise.
REQ-007 The block SHALL implement the state machine IDLE, EXT, BRK, EXT_BRK.
REQ-008 In IDLE: E0 -> EXT; F0 -> BRK; bytes FA, AA, EE, FE, 00, FF -> ignored, stay in IDLE; any other byte -> non-extended make, stay in IDLE.
REQ-009 In EXT: F0 -> EXT_BRK; E0 -> stay in EXT with no error (tolerated duplicate); any other byte -> extended make, then IDLE.
REQ-010 In BRK, the next byte SHALL be a non-extended break, then IDLE; if that byte is E0 or F0, the block SHALL pulse seq_error, go to IDLE, and change no key.
REQ-011 In EXT_BRK, the next byte SHALL be an extended break, then IDLE; if that byte is E0 or F0, the block SHALL pulse seq_error, go to IDLE, and change no key.
REQ-012 A make or break SHALL match key i only when byte == KEY_CODES[i] and the extended flag equals KEY_EXT[i]; every matching index SHALL be updated, and a non-matching code SHALL cause no output change.
REQ-013 A make on key i with key_held[i]=0 SHALL set key_held[i] and pulse key_press[i]; a make with key_held[i]=1 (typematic repeat) SHALL produce no pulse.
REQ-014 A break on key i with key_held[i]=1 SHALL clear key_held[i] and pulse key_release[i]; a break with key_held[i]=0 SHALL produce no pulse.
REQ-015 All outputs SHALL be registered; key_held, pulses and seq_error SHALL change in the cycle after the accepted byte (latency 1).
REQ-016 The timeout counter SHALL reset on every accepted byte and SHALL count while the state is not IDLE; after TIMEOUT consecutive cycles without byte_valid, the block SHALL go to IDLE, pulse seq_error once, and keep key_held unchanged.
REQ-017 The timeout counter SHALL be held at 0 in IDLE.
REQ-018 flush=1 SHALL go to IDLE, clear the counter, clear all key_held bits, and pulse key_release for every bit that was held.
REQ-019 When flush=1 and byte_valid=1 in the same cycle, flush SHALL win and the byte SHALL be dropped.
REQ-020 Pulse outputs SHALL be 0 in every cycle not named in REQ-013, REQ-014, REQ-010, REQ-011, REQ-016 or REQ-018.

Reset
REQ-021 Asserting reset SHALL immediately force state IDLE, counter 0, key_held 0, key_press 0, key_release 0 and seq_error 0, including when asserted mid-sequence.
REQ-022 Reset SHALL generate no release pulses.
REQ-023 The first byte accepted after reset deasserts SHALL be decoded from IDLE.

Verification
REQ-024 Bytes E0,75 -> key_held=4'b0001 and key_press=4'b0001 for one cycle; bytes E0,75 again -> no pulse; bytes E0,F0,75 -> key_held=0 and key_release=4'b0001 pulsed.
REQ-025 Byte 29 -> key 3 held; byte 75 without E0 -> no change; bytes F0,29 -> key 3 released.
REQ-026 Bytes E0,74 then E0,6B -> key_held=4'b0110; flush together with byte_valid of E0 -> key_held=0, key_release=4'b0110, and a following 74 is treated as a non-extended make (no change).
REQ-027 Byte E0 then TIMEOUT idle cycles -> seq_error pulses once and state is IDLE; a following 29 sets key 3.
REQ-028 Bytes F0,E0 -> seq_error pulses and key_held is unchanged; reset asserted after E0,F0 -> all outputs 0, and a following 75 is a non-extended make (no change).
